// File: rtl/infinite_loop_serializer_pkg.sv
// ---------------------------------------------------------------------------
// infinite_loop_serializer_pkg
// Shared definitions for the infinite-mode loop serializer: the controller
// state encoding and the default sample/address widths. The RAM and the
// output-mux wrapper use the same defaults.
// Ports: none (package).
// ---------------------------------------------------------------------------
package infinite_loop_serializer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PRIME = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/infinite_loop_serializer_if.sv
// ---------------------------------------------------------------------------
// infinite_loop_serializer_if
// Bundles the control, RAM-read and serial-output signals of the loop
// serializer.
//   master : the serializer (drives Rd_En/Rd_Addr and the serial outputs)
//   slave  : its environment (controller, waveform RAM, output mux)
// Signals: Start, Stop, Start_Addr, End_Addr (control in); Rd_En, Rd_Addr,
// Rd_Data (RAM read port); Dout, Bit_Valid, Sel_Inf, Wrap_Pulse, Busy.
// ---------------------------------------------------------------------------
interface infinite_loop_serializer_if
  import infinite_loop_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              Start;
  logic              Stop;
  logic [ADDR_W-1:0] Start_Addr;
  logic [ADDR_W-1:0] End_Addr;
  logic              Rd_En;
  logic [ADDR_W-1:0] Rd_Addr;
  logic [DATA_W-1:0] Rd_Data;
  logic              Dout;
  logic              Bit_Valid;
  logic              Sel_Inf;
  logic              Wrap_Pulse;
  logic              Busy;

  modport master (
    input  Start, Stop, Start_Addr, End_Addr, Rd_Data,
    output Rd_En, Rd_Addr, Dout, Bit_Valid, Sel_Inf, Wrap_Pulse, Busy
  );

  modport slave (
    output Start, Stop, Start_Addr, End_Addr, Rd_Data,
    input  Rd_En, Rd_Addr, Dout, Bit_Valid, Sel_Inf, Wrap_Pulse, Busy
  );

endinterface

// File: rtl/infinite_loop_serializer_loop_addr_gen.sv
// ---------------------------------------------------------------------------
// loop_addr_gen
// Owns the loop window (latched start/end), the read address register and the
// wrap indication.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : latch start_addr/end_addr, address := start_addr
//   advance     : step the address to the next word of the window
//   start_addr  : window first address (sampled on load only)
//   end_addr    : window last address, inclusive (sampled on load only)
//   addr        : current read address (register output)
//   wrap_pulse  : high in the cycle a read is issued at the window end
// ---------------------------------------------------------------------------
module loop_addr_gen
  import infinite_loop_serializer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap_pulse
);

  logic [ADDR_W-1:0] s_addr_r;
  logic [ADDR_W-1:0] e_addr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] next_addr_s;
  logic              wrap_r;

  // Next address: back to the window start after the end word, otherwise
  // increment; the increment wraps naturally at 2^ADDR_W, which is what makes
  // an End_Addr below Start_Addr window run through the top of the RAM.
  always_comb begin
    next_addr_s = addr_r;
    if (addr_r == e_addr_r) begin
      next_addr_s = s_addr_r;
    end else begin
      next_addr_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Window latch, address register and wrap flag; the wrap flag is timed with
  // the read strobe that the top raises on the same load/advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_addr_r <= {ADDR_W{1'b0}};
      e_addr_r <= {ADDR_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
      wrap_r   <= 1'b0;
    end else if (load) begin
      s_addr_r <= start_addr;
      e_addr_r <= end_addr;
      addr_r   <= start_addr;
      wrap_r   <= (start_addr == end_addr);
    end else if (advance) begin
      addr_r   <= next_addr_s;
      wrap_r   <= (next_addr_s == e_addr_r);
    end else begin
      wrap_r   <= 1'b0;
    end
  end

  assign addr       = addr_r;
  assign wrap_pulse = wrap_r;

endmodule

// File: rtl/infinite_loop_serializer.sv
// ---------------------------------------------------------------------------
// infinite_loop_serializer
// Replays a window of the waveform RAM forever, serializing each sample
// MSB-first into a gapless bit stream for the infinite-mode output mux.
//   Clock   : system clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : master side of infinite_loop_serializer_if
//             Start/Stop pulses, window addresses, RAM read port,
//             Dout/Bit_Valid/Sel_Inf to the mux, Wrap_Pulse, Busy.
// The next word is fetched at bit 0 of the current one and parked in a hold
// register, so it is ready for the shift register at the last bit.
// ---------------------------------------------------------------------------
module infinite_loop_serializer
  import infinite_loop_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  infinite_loop_serializer_if.master bus
);

  localparam int               CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              load_s;
  logic              advance_s;
  logic              last_bit_s;
  logic              stop_now_s;
  logic              hold_cap_s;
  logic [DATA_W-1:0] hold_nxt_s;

  logic [DATA_W-1:0] sr_r;
  logic [DATA_W-1:0] hold_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              stop_pending_r;
  logic              rd_en_r;
  logic              run_r;
  logic              busy_r;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              wrap_pulse_s;

  loop_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .load       (load_s),
    .advance    (advance_s),
    .start_addr (bus.Start_Addr),
    .end_addr   (bus.End_Addr),
    .addr       (rd_addr_s),
    .wrap_pulse (wrap_pulse_s)
  );

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus the load/advance strobes for the address generator.
  // A Stop arriving in the last-bit cycle itself still ends the loop there.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    advance_s   = 1'b0;
    stop_now_s  = stop_pending_r | bus.Stop;
    last_bit_s  = (state_r == ST_RUN) && (bit_cnt_r == LAST_BIT);
    hold_cap_s  = (state_r == ST_RUN) && (bit_cnt_r == CNT_ONE);
    // With DATA_W==2 capture and reload coincide, so bypass the hold register.
    hold_nxt_s  = hold_cap_s ? bus.Rd_Data : hold_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.Start) begin
          state_nxt_s = ST_FETCH;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_PRIME;
      end
      ST_PRIME: begin
        state_nxt_s = ST_RUN;
        advance_s   = 1'b1;
      end
      ST_RUN: begin
        if (last_bit_s && stop_now_s) begin
          state_nxt_s = ST_IDLE;
        end else if (last_bit_s) begin
          state_nxt_s = ST_RUN;
          advance_s   = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Registered flags, stop request, hold register and the shift datapath.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_en_r        <= 1'b0;
      run_r          <= 1'b0;
      busy_r         <= 1'b0;
      stop_pending_r <= 1'b0;
      hold_r         <= {DATA_W{1'b0}};
      sr_r           <= {DATA_W{1'b0}};
      bit_cnt_r      <= {CNT_W{1'b0}};
    end else begin
      rd_en_r <= load_s | advance_s;
      run_r   <= (state_nxt_s == ST_RUN);
      busy_r  <= (state_nxt_s != ST_IDLE);

      if (state_nxt_s == ST_IDLE) begin
        stop_pending_r <= 1'b0;
      end else if ((state_r != ST_IDLE) && bus.Stop) begin
        stop_pending_r <= 1'b1;
      end else begin
        stop_pending_r <= stop_pending_r;
      end

      if (hold_cap_s) begin
        hold_r <= bus.Rd_Data;
      end else begin
        hold_r <= hold_r;
      end

      case (state_r)
        ST_PRIME: begin
          sr_r      <= bus.Rd_Data;
          bit_cnt_r <= {CNT_W{1'b0}};
        end
        ST_RUN: begin
          if (last_bit_s) begin
            // Clearing on stop drops the prefetched word and forces Dout low.
            sr_r      <= stop_now_s ? {DATA_W{1'b0}} : hold_nxt_s;
            bit_cnt_r <= {CNT_W{1'b0}};
          end else begin
            sr_r      <= {sr_r[DATA_W-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
          end
        end
        default: begin
          sr_r      <= {DATA_W{1'b0}};
          bit_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.Rd_En      = rd_en_r;
  assign bus.Rd_Addr    = rd_addr_s;
  assign bus.Dout       = sr_r[DATA_W-1];
  assign bus.Bit_Valid  = run_r;
  assign bus.Sel_Inf    = run_r;
  assign bus.Wrap_Pulse = wrap_pulse_s;
  assign bus.Busy       = busy_r;

endmodule

// File: tb/tb_infinite_loop_serializer.sv
// ---------------------------------------------------------------------------
// tb_infinite_loop_serializer
// Directed bench for infinite_loop_serializer with a 1-cycle-latency RAM model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_infinite_loop_serializer;

  localparam int DW = 16;
  localparam int AW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  infinite_loop_serializer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  infinite_loop_serializer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // RAM model: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.Rd_En) bus.Rd_Data <= mem[bus.Rd_Addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues Start and checks the FETCH/PRIME cycles; returns at the first bit.
  task automatic start_loop(input logic [AW-1:0] s, input logic [AW-1:0] e,
                            input logic exp_wrap);
    bus.Start = 1'b1; bus.Start_Addr = s; bus.End_Addr = e;
    step();
    bus.Start = 1'b0;
    checks++;
    if ({bus.Rd_En, bus.Rd_Addr, bus.Wrap_Pulse, bus.Busy, bus.Bit_Valid} !== {1'b1, s, exp_wrap, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fetch: rd_en=%b addr=%0d wrap=%b busy=%b bv=%b, want 1 %0d %b 1 0",
               bus.Rd_En, bus.Rd_Addr, bus.Wrap_Pulse, bus.Busy, bus.Bit_Valid, s, exp_wrap);
    end
    step();
    checks++;
    if ({bus.Bit_Valid, bus.Rd_En, bus.Sel_Inf, bus.Busy} !== 4'b0001) begin
      errors++;
      $display("FAIL prime: bv/rd/sel/busy=%b%b%b%b, want 0001",
               bus.Bit_Valid, bus.Rd_En, bus.Sel_Inf, bus.Busy);
    end
    step();
    checks++;
    if ({bus.Bit_Valid, bus.Sel_Inf} !== 2'b11) begin
      errors++;
      $display("FAIL first_bit_latency: bv/sel=%b%b, want 11", bus.Bit_Valid, bus.Sel_Inf);
    end
  endtask

  // Requests a stop and waits (bounded) for the block to go idle.
  task automatic drain(input string tag);
    int n;
    n = 0;
    bus.Stop = 1'b1;
    step();
    bus.Stop = 1'b0;
    while (bus.Busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (bus.Busy !== 1'b0 || bus.Bit_Valid !== 1'b0 || bus.Sel_Inf !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: busy=%b bv=%b sel=%b after %0d cycles, want 0 0 0",
               tag, bus.Busy, bus.Bit_Valid, bus.Sel_Inf, n);
    end
  endtask

  task automatic test_reset();
    bus.Start = 1'b0; bus.Stop = 1'b0; bus.Start_Addr = '0; bus.End_Addr = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.Busy, bus.Sel_Inf, bus.Bit_Valid, bus.Dout, bus.Rd_En, bus.Wrap_Pulse, bus.Rd_Addr} !== 16'd0) begin
      errors++;
      $display("FAIL reset_async: busy/sel/bv/dout/rd/wrap=%b%b%b%b%b%b addr=%0d, want all 0",
               bus.Busy, bus.Sel_Inf, bus.Bit_Valid, bus.Dout, bus.Rd_En, bus.Wrap_Pulse, bus.Rd_Addr);
    end
    step(); step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.Busy, bus.Sel_Inf, bus.Bit_Valid, bus.Dout, bus.Rd_En} !== 5'd0) begin
      errors++;
      $display("FAIL reset_idle: busy/sel/bv/dout/rd=%b%b%b%b%b, want 00000",
               bus.Busy, bus.Sel_Inf, bus.Bit_Valid, bus.Dout, bus.Rd_En);
    end
  endtask

  task automatic test_loop_two_words();
    logic [DW-1:0] w;
    logic [3:0]    got, exp;
    mem[0] = 16'hA5A5; mem[1] = 16'hFFFF;
    start_loop(10'd0, 10'd1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      w   = ((i / 16) % 2 == 0) ? 16'hA5A5 : 16'hFFFF;
      exp = {1'b1, w[4'(15 - i % 16)], (i % 16 == 0), (i % 32 == 0)};
      got = {bus.Bit_Valid, bus.Dout, bus.Rd_En, bus.Wrap_Pulse};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL two_words cycle %0d: bv/dout/rd/wrap=%b, want %b", i, got, exp);
      end
      step();
    end
    drain("two_words");
  endtask

  task automatic test_single_word();
    logic [DW-1:0] w;
    logic [13:0]   got, exp;
    w = 16'h8001;
    mem[5] = w;
    start_loop(10'd5, 10'd5, 1'b1);
    for (int i = 0; i < 48; i++) begin
      exp = {1'b1, w[4'(15 - i % 16)], (i % 16 == 0), (i % 16 == 0), 10'd5};
      got = {bus.Bit_Valid, bus.Dout, bus.Rd_En, bus.Wrap_Pulse, bus.Rd_Addr};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_word cycle %0d: bv/dout/rd/wrap/addr=%b, want %b", i, got, exp);
      end
      step();
    end
    drain("single_word");
  endtask

  task automatic test_wrap_window();
    int unsigned   seq [6];
    logic [DW-1:0] w;
    logic [3:0]    got, exp;
    seq = '{1022, 1023, 0, 1, 1022, 1023};
    mem[1022] = 16'hF00F; mem[1023] = 16'h0FF0; mem[0] = 16'hAAAA; mem[1] = 16'h5555;
    start_loop(10'd1022, 10'd1, 1'b0);
    for (int i = 0; i < 80; i++) begin
      w   = mem[seq[i / 16]];
      exp = {1'b1, w[4'(15 - i % 16)], (i % 16 == 0), (i % 16 == 0) && (seq[i / 16 + 1] == 1)};
      got = {bus.Bit_Valid, bus.Dout, bus.Rd_En, bus.Wrap_Pulse};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL wrap_window cycle %0d: bv/dout/rd/wrap=%b, want %b", i, got, exp);
      end
      if (i % 16 == 0) begin
        checks++;
        if (bus.Rd_Addr !== 10'(seq[i / 16 + 1])) begin
          errors++;
          $display("FAIL wrap_addr cycle %0d: rd_addr=%0d, want %0d", i, bus.Rd_Addr, seq[i / 16 + 1]);
        end
      end
      step();
    end
    drain("wrap_window");
  endtask

  task automatic test_stop();
    logic [DW-1:0] w;
    logic [5:0]    got, exp;
    w = 16'hAAAA;
    mem[0] = w; mem[1] = 16'h5555; mem[2] = 16'hC3C3;
    start_loop(10'd0, 10'd1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      exp = {1'b1, w[4'(15 - i)], (i == 0), (i == 0), 1'b1, 1'b1};
      got = {bus.Bit_Valid, bus.Dout, bus.Rd_En, bus.Wrap_Pulse, bus.Sel_Inf, bus.Busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stop_word bit %0d: bv/dout/rd/wrap/sel/busy=%b, want %b", i, got, exp);
      end
      bus.Stop = (i == 3);
      step();
    end
    bus.Stop = 1'b0;
    got = {bus.Bit_Valid, bus.Dout, bus.Rd_En, bus.Wrap_Pulse, bus.Sel_Inf, bus.Busy};
    checks++;
    if (got !== 6'd0) begin
      errors++;
      $display("FAIL stop_idle: bv/dout/rd/wrap/sel/busy=%b, want 000000", got);
    end
    // Restart immediately in the first idle cycle.
    w = 16'hC3C3;
    start_loop(10'd2, 10'd2, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({bus.Bit_Valid, bus.Dout} !== {1'b1, w[4'(15 - i)]}) begin
        errors++;
        $display("FAIL restart bit %0d: bv/dout=%b%b, want 1%b", i, bus.Bit_Valid, bus.Dout, w[4'(15 - i)]);
      end
      step();
    end
    drain("restart");
  endtask

  task automatic test_start_ignored();
    logic [DW-1:0] w;
    logic [13:0]   got, exp;
    w = 16'hC3C3;
    mem[7] = 16'h0000; mem[8] = 16'h0000; mem[9] = 16'h0000;
    start_loop(10'd2, 10'd2, 1'b1);
    for (int i = 0; i < 32; i++) begin
      exp = {1'b1, w[4'(15 - i % 16)], (i % 16 == 0), (i % 16 == 0), 10'd2};
      got = {bus.Bit_Valid, bus.Dout, bus.Rd_En, bus.Wrap_Pulse, bus.Rd_Addr};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL start_ignored cycle %0d: bv/dout/rd/wrap/addr=%b, want %b", i, got, exp);
      end
      bus.Start = (i == 5) || (i == 20);
      bus.Stop  = (i == 20);
      bus.Start_Addr = 10'd7;
      bus.End_Addr   = 10'd9;
      step();
    end
    bus.Start = 1'b0; bus.Stop = 1'b0;
    checks++;
    if ({bus.Bit_Valid, bus.Sel_Inf, bus.Busy, bus.Rd_En, bus.Dout} !== 5'd0) begin
      errors++;
      $display("FAIL start_stop_idle: bv/sel/busy/rd/dout=%b%b%b%b%b, want 00000",
               bus.Bit_Valid, bus.Sel_Inf, bus.Busy, bus.Rd_En, bus.Dout);
    end
  endtask

  task automatic test_reset_mid_word();
    mem[0] = 16'hAAAA; mem[1] = 16'h5555;
    start_loop(10'd0, 10'd1, 1'b0);
    step(); step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.Busy, bus.Sel_Inf, bus.Bit_Valid, bus.Dout, bus.Rd_En, bus.Wrap_Pulse, bus.Rd_Addr} !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_word: busy/sel/bv/dout/rd/wrap=%b%b%b%b%b%b addr=%0d, want all 0",
               bus.Busy, bus.Sel_Inf, bus.Bit_Valid, bus.Dout, bus.Rd_En, bus.Wrap_Pulse, bus.Rd_Addr);
    end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({bus.Bit_Valid, bus.Busy, bus.Rd_En, bus.Sel_Inf, bus.Dout} !== 5'd0) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d: bv/busy/rd/sel/dout=%b%b%b%b%b, want 00000",
                 i, bus.Bit_Valid, bus.Busy, bus.Rd_En, bus.Sel_Inf, bus.Dout);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    test_reset();
    test_loop_two_words();
    test_single_word();
    test_wrap_window();
    test_stop();
    test_start_ignored();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at time %0t, want finished earlier", $time);
    $fatal(1);
  end

endmodule
